// File: rtl/line_buffer_scheduler_pkg.sv
// Shared constants, types and helpers for the line buffer scheduler.
// Holds line/slot geometry, address field widths and the read-FSM encoding.
package line_buffer_scheduler_pkg;

    localparam int LINE_PIXELS_DEF = 64;
    localparam int NUM_SLOTS_DEF   = 16;

    localparam int IDX_W  = 6;               // pixel index inside a slot
    localparam int SLOT_W = 4;               // slot number
    localparam int ADDR_W = SLOT_W + IDX_W;  // BRAM word address
    localparam int PCNT_W = 10;              // incoming pixel counter
    localparam int PIX_W  = 12;              // pixel sample
    localparam int WORD_W = 16;              // BRAM word
    localparam int CNT_W  = 5;               // committed-line counter, 0..NUM_SLOTS

    // Read sequencer states
    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_ISSUE = 2'd1,
        R_DRAIN = 2'd2
    } rd_state_t;

    // One registered write request towards the BRAM port
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] din;
    } wr_req_t;

    // Advance a slot pointer, wrapping at num_slots
    function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] slot,
                                                    input int                num_slots);
        return (int'(slot) == num_slots - 1) ? '0 : slot + 1'b1;
    endfunction

endpackage

// File: rtl/line_buffer_scheduler_readout.sv
// Line readout sequencer: walks one slot word by word, stalling whenever the
// write path owns the BRAM port, and delivers registered read data two
// cycles after each issued address.
module line_readout_fsm
    import line_buffer_scheduler_pkg::*;
#(
    parameter int LINE_PIXELS = LINE_PIXELS_DEF
) (
    input  logic              SDR_CLK,
    input  logic              RST,
    input  logic              start,     // already qualified by "lines available"
    input  logic              stall,     // BRAM port taken by a write this cycle
    input  logic [WORD_W-1:0] mem_dout,
    output logic [IDX_W-1:0]  rd_idx,
    output logic              rd_busy,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              rd_done    // final word delivered: release the slot
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_PIXELS - 1);

    rd_state_t state;
    logic      rd_issue;
    logic      issue_d;
    logic      last_d;

    assign rd_issue = (state == R_ISSUE) && !stall;
    assign rd_done  = (state == R_DRAIN) && rd_valid && rd_last;

    // Sequencer: start on request, issue one word per free port cycle, drain the pipe
    always_ff @(posedge SDR_CLK or posedge RST) begin
        if (RST) begin
            state   <= R_IDLE;
            rd_idx  <= '0;
            rd_busy <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register here see the
            // pre-edge values of the others, which is what real flops do.
            case (state)
                R_IDLE: begin
                    if (start) begin
                        state   <= R_ISSUE;
                        rd_idx  <= '0;
                        rd_busy <= 1'b1;
                    end
                end
                R_ISSUE: begin
                    if (!stall) begin
                        if (rd_idx == LAST_IDX) begin
                            state <= R_DRAIN;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                R_DRAIN: begin
                    if (rd_done) begin
                        state   <= R_IDLE;
                        rd_idx  <= '0;
                        rd_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= R_IDLE;
                    rd_busy <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage qualifier pipe matching BRAM latency plus the output register
    always_ff @(posedge SDR_CLK or posedge RST) begin
        if (RST) begin
            issue_d  <= 1'b0;
            last_d   <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else begin
            issue_d  <= rd_issue;
            last_d   <= rd_issue && (rd_idx == LAST_IDX);
            rd_valid <= issue_d;
            rd_last  <= last_d;
            rd_data  <= mem_dout;
        end
    end

endmodule

// File: rtl/line_buffer_scheduler.sv
// Line buffer scheduler: streams incoming lines into slots of a shared
// single-port BRAM, tracks committed lines, and arbitrates the port between
// the write stream (always wins) and the line readout sequencer.
module line_buffer_scheduler
    import line_buffer_scheduler_pkg::*;
#(
    parameter int LINE_PIXELS = LINE_PIXELS_DEF,
    parameter int NUM_SLOTS   = NUM_SLOTS_DEF
) (
    input  logic              SDR_CLK,
    input  logic              RST,
    input  logic              Write_EN,
    input  logic [PCNT_W-1:0] Pixel_count,
    input  logic [PIX_W-1:0]  Pixel_data,
    input  logic              Rd_start,
    input  logic              Ovf_clr,
    input  logic [WORD_W-1:0] Mem_dout,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic [WORD_W-1:0] Mem_din,
    output logic              Mem_we,
    output logic [WORD_W-1:0] Rd_data,
    output logic              Rd_valid,
    output logic              Rd_last,
    output logic              Rd_busy,
    output logic [CNT_W-1:0]  Lines_avail,
    output logic              Overflow
);

    wr_req_t            wr_req;
    logic               write_en_d;
    logic               line_drop;
    logic [SLOT_W-1:0]  wr_slot;
    logic [SLOT_W-1:0]  rd_slot;
    logic [IDX_W-1:0]   rd_idx;
    logic               rd_done;

    logic wen_rise;
    logic wen_fall;
    logic lines_full;
    logic drop_now;
    logic pix_in_line;
    logic commit;
    logic rd_go;

    // Line boundaries come from the sampled Write_EN edges
    assign wen_rise    = Write_EN && !write_en_d;
    assign wen_fall    = !Write_EN && write_en_d;
    assign lines_full  = (Lines_avail == CNT_W'(NUM_SLOTS));
    // The drop decision is taken on the first pixel and then held for the line
    assign drop_now    = wen_rise ? lines_full : line_drop;
    assign pix_in_line = (Pixel_count < PCNT_W'(LINE_PIXELS));
    // A fall with count 0 is a spurious pulse: the slot is simply reused
    assign commit      = wen_fall && (Pixel_count != '0) && !line_drop;
    assign rd_go       = Rd_start && (Lines_avail != '0);

    // The port follows the registered write enable; reads fill the idle cycles
    assign Mem_we   = wr_req.we;
    assign Mem_din  = wr_req.din;
    assign Mem_addr = wr_req.we ? wr_req.addr : {rd_slot, rd_idx};

    // Registered write request plus edge-detect and per-line drop flag
    always_ff @(posedge SDR_CLK or posedge RST) begin
        if (RST) begin
            wr_req     <= '0;
            write_en_d <= 1'b0;
            line_drop  <= 1'b0;
        end else begin
            write_en_d  <= Write_EN;
            if (wen_rise) begin
                line_drop <= lines_full;
            end
            wr_req.we   <= Write_EN && !drop_now && pix_in_line;
            wr_req.addr <= {wr_slot, Pixel_count[IDX_W-1:0]};
            wr_req.din  <= {{(WORD_W - PIX_W){1'b0}}, Pixel_data};
        end
    end

    // Slot pointers and committed-line count; commit and release may coincide
    always_ff @(posedge SDR_CLK or posedge RST) begin
        if (RST) begin
            wr_slot     <= '0;
            rd_slot     <= '0;
            Lines_avail <= '0;
        end else begin
            if (commit) begin
                wr_slot <= next_slot(wr_slot, NUM_SLOTS);
            end
            if (rd_done) begin
                rd_slot <= next_slot(rd_slot, NUM_SLOTS);
            end
            case ({commit, rd_done})
                2'b10:   Lines_avail <= Lines_avail + 1'b1;
                2'b01:   Lines_avail <= Lines_avail - 1'b1;
                default: Lines_avail <= Lines_avail;
            endcase
        end
    end

    // Sticky overflow: a dropped line outranks a clear in the same cycle
    always_ff @(posedge SDR_CLK or posedge RST) begin
        if (RST) begin
            Overflow <= 1'b0;
        end else if (wen_rise && lines_full) begin
            Overflow <= 1'b1;
        end else if (Ovf_clr) begin
            Overflow <= 1'b0;
        end
    end

    line_readout_fsm #(
        .LINE_PIXELS (LINE_PIXELS)
    ) u_readout (
        .SDR_CLK  (SDR_CLK),
        .RST      (RST),
        .start    (rd_go),
        .stall    (wr_req.we),
        .mem_dout (Mem_dout),
        .rd_idx   (rd_idx),
        .rd_busy  (Rd_busy),
        .rd_data  (Rd_data),
        .rd_valid (Rd_valid),
        .rd_last  (Rd_last),
        .rd_done  (rd_done)
    );

endmodule
